// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry head/skid storage with occupancy FSM. The head register drives the
// stream data directly; the skid register catches a word popped while the head
// is stalled.
module stream_skid_buffer
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DataWidth-1:0] push_data,
    input  logic                 take,
    output occ_state_t           state,
    output logic [DataWidth-1:0] head_data
);

    occ_state_t           state_q, state_d;
    logic [DataWidth-1:0] head_q, head_d;
    logic [DataWidth-1:0] skid_q, skid_d;

    // Next occupancy and storage contents; a push goes to the head whenever
    // the head is free or its word leaves in this cycle, otherwise to the skid.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && take) begin
                    head_d = push_data;
                end else if (push) begin
                    skid_d  = push_data;
                    state_d = OCC_TWO;
                end else if (take) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (take) begin
                    head_d  = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    // Occupancy and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign state     = state_q;
    assign head_data = head_q;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Read-side drain stage: pops words from an upstream FIFO and presents them as
// a registered valid/ready stream, marking every BurstLen-th word with outLast.
// Optional statistics ports (wordCount, burstCount) are enabled by defining
// FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter
    import fifo_pkg::*;
#(
    parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH,
    parameter int unsigned BurstLen  = 4,
    parameter int unsigned BeatWidth = (BurstLen > 1) ? $clog2(BurstLen) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifoEmpty,
    input  logic [DataWidth-1:0] fifoReadData,
    output logic                 fifoReadEn,
    output logic                 outValid,
    input  logic                 outReady,
    output logic [DataWidth-1:0] outData,
    output logic                 outLast
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]          wordCount,
    output logic [15:0]          burstCount
`endif
);

    localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(BurstLen - 1);

    occ_state_t           occ_state;
    logic [DataWidth-1:0] head_data;
    logic                 pop;
    logic                 take;
    logic [BeatWidth-1:0] beat_q, beat_d;

    // Pop request depends only on registered occupancy and the empty flag, so
    // there is no combinational path from outReady back to the FIFO.
    assign fifoReadEn = !rst && !fifoEmpty && (occ_state != OCC_TWO);
    assign pop        = fifoReadEn && !fifoEmpty;
    assign outValid   = (occ_state != OCC_EMPTY);
    assign take       = outValid && outReady;
    assign outData    = head_data;
    assign outLast    = outValid && (beat_q == LastBeat);

    stream_skid_buffer #(
        .DataWidth (DataWidth)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (pop),
        .push_data (fifoReadData),
        .take      (take),
        .state     (occ_state),
        .head_data (head_data)
    );

    // Beat position within the current burst, advanced per accepted word.
    always_comb begin
        beat_d = beat_q;
        if (take) begin
            if (beat_q == LastBeat) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] word_count_q, word_count_d;
    logic [15:0] burst_count_q, burst_count_d;

    // Free-running transfer statistics, both wrapping naturally.
    always_comb begin
        word_count_d  = word_count_q;
        burst_count_d = burst_count_q;
        if (take) begin
            word_count_d = word_count_q + 32'd1;
            if (outLast) begin
                burst_count_d = burst_count_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_count_q  <= '0;
            burst_count_q <= '0;
        end else begin
            word_count_q  <= word_count_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign wordCount  = word_count_q;
    assign burstCount = burst_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Self-checking bench for fifo_stream_adapter: a queue-based FIFO source and a
// queue-based buffer/beat reference model drive per-cycle expectations.
module tb_fifo_stream_adapter;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic        f_empty;
    logic [31:0] f_data;
    logic        f_rd_en;
    logic        o_valid;
    logic        o_ready;
    logic [31:0] o_data;
    logic        o_last;

    logic        f1_empty;
    logic [31:0] f1_data;
    logic        f1_rd_en;
    logic        o1_valid;
    logic        o1_ready;
    logic [31:0] o1_data;
    logic        o1_last;

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    logic [31:0] w0_count;
    logic [15:0] b0_count;
    logic [31:0] w1_count;
    logic [15:0] b1_count;
`endif

    fifo_stream_adapter #(
        .DataWidth (32),
        .BurstLen  (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifoEmpty    (f_empty),
        .fifoReadData (f_data),
        .fifoReadEn   (f_rd_en),
        .outValid     (o_valid),
        .outReady     (o_ready),
        .outData      (o_data),
        .outLast      (o_last)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .wordCount    (w0_count),
        .burstCount   (b0_count)
`endif
    );

    fifo_stream_adapter #(
        .DataWidth (32),
        .BurstLen  (1)
    ) dut_bl1 (
        .clk          (clk),
        .rst          (rst),
        .fifoEmpty    (f1_empty),
        .fifoReadData (f1_data),
        .fifoReadEn   (f1_rd_en),
        .outValid     (o1_valid),
        .outReady     (o1_ready),
        .outData      (o1_data),
        .outLast      (o1_last)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        ,
        .wordCount    (w1_count),
        .burstCount   (b1_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Upstream FIFO contents, words held by the adapter, and accepted words.
    logic [31:0] fifo_q[$];
    logic [31:0] buf_q[$];
    logic [31:0] taken_log[$];
    bit          last_log[$];
    int          beat;
    int          since_rst_words;
    int          since_rst_bursts;
    int          pop_count;

    bit          rst_drive;
    bit          hold_empty;
    int          ready_mode;

    logic        s_valid;
    logic        s_rd_en;
    logic        s_last;
    logic [31:0] s_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle of the main instance against the reference model.
    task automatic cycle0();
        bit exp_valid;
        bit exp_rd;
        bit exp_last;
        bit take;
        bit pop;
        @(negedge clk);
        rst     = rst_drive;
        f_empty = hold_empty || (fifo_q.size() == 0);
        f_data  = (fifo_q.size() != 0) ? fifo_q[0] : $urandom;
        case (ready_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = 1'b0;
            2:       o_ready = ~o_ready;
            default: o_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (rst) begin
            buf_q.delete();
            beat             = 0;
            since_rst_words  = 0;
            since_rst_bursts = 0;
        end
        exp_valid = (buf_q.size() != 0);
        exp_rd    = !rst && !f_empty && (buf_q.size() < 2);
        exp_last  = exp_valid && (beat == BL - 1);
        s_valid   = o_valid;
        s_rd_en   = f_rd_en;
        s_last    = o_last;
        s_data    = o_data;
        check("valid", 32'(o_valid), 32'(exp_valid));
        check("rd_en", 32'(f_rd_en), 32'(exp_rd));
        check("last",  32'(o_last),  32'(exp_last));
        if (exp_valid) check("data", o_data, buf_q[0]);
        take = exp_valid && o_ready;
        pop  = exp_rd;
        if (pop) pop_count++;
        @(posedge clk);
        if (!rst) begin
            if (take) begin
                taken_log.push_back(buf_q.pop_front());
                last_log.push_back(exp_last);
                since_rst_words++;
                if (exp_last) since_rst_bursts++;
                beat = (beat + 1) % BL;
            end
            if (pop) buf_q.push_back(fifo_q.pop_front());
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle0();
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (((fifo_q.size() + buf_q.size()) != 0) && (n < max_cycles)) begin
            cycle0();
            n++;
        end
        check(tag, 32'(fifo_q.size() + buf_q.size()), 32'd0);
    endtask

    // Accepted words must be base, base+1, ... with outLast on every BL-th from beat 0.
    task automatic check_run(input string tag, input logic [31:0] base, input int n);
        check({tag, "_count"}, 32'(taken_log.size()), 32'(n));
        for (int i = 0; i < n && i < taken_log.size(); i++) begin
            check({tag, "_word"}, taken_log[i], base + 32'(i));
            check({tag, "_lastflag"}, 32'(last_log[i]), 32'((i % BL) == BL - 1));
        end
        taken_log.delete();
        last_log.delete();
    endtask

    task automatic preload(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    endtask

    initial begin
        int n1;
        bit p1;
        int bad;
        logic [31:0] q1[$];

        checks     = 0;
        failures   = 0;
        beat       = 0;
        rst        = 1'b1;
        rst_drive  = 1'b1;
        hold_empty = 1'b0;
        ready_mode = 0;
        f_empty    = 1'b1;
        f_data     = '0;
        o_ready    = 1'b0;
        f1_empty   = 1'b1;
        f1_data    = '0;
        o1_ready   = 1'b0;

        // Reset state.
        run(2);
        check("rst_data", s_data, 32'd0);
        check("rst_last", 32'(s_last), 32'd0);
        rst_drive = 1'b0;
        run(1);

        // FIFO flag held high although words exist: nothing moves.
        hold_empty = 1'b1;
        preload(32'h900, 3);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            cycle0();
            if (s_rd_en || s_valid) bad++;
        end
        check("empty_idle", 32'(bad), 32'd0);
        fifo_q.delete();
        hold_empty = 1'b0;

        // Preloaded 1..8 with ready held high: 8 back-to-back pops.
        preload(32'h1, 8);
        ready_mode = 0;
        pop_count  = 0;
        bad        = 0;
        for (int i = 0; i < 8; i++) begin
            cycle0();
            if (!s_rd_en) bad++;
        end
        check("t2_pop_streak", 32'(bad), 32'd0);
        check("t2_pops", 32'(pop_count), 32'd8);
        drain("t2_drain", 20);
        check_run("t2", 32'h1, 8);

        // Stalled consumer: two pops fill head and skid, head word stays put.
        preload(32'hA, 3);
        ready_mode = 1;
        pop_count  = 0;
        run(6);
        check("t3_pops", 32'(pop_count), 32'd2);
        check("t3_rd_en", 32'(s_rd_en), 32'd0);
        check("t3_head", s_data, 32'hA);
        check("t3_held", 32'(buf_q.size()), 32'd2);
        ready_mode = 0;
        drain("t3_drain", 20);
        check_run("t3", 32'hA, 3);

        // Reset with both entries occupied discards them; bursts restart at beat 0.
        preload(32'h100, 6);
        ready_mode = 1;
        run(4);
        check("t1_full", 32'(s_rd_en), 32'd0);
        rst_drive = 1'b1;
        run(1);
        check("t1_valid", 32'(s_valid), 32'd0);
        check("t1_last", 32'(s_last), 32'd0);
        check("t1_rd_en", 32'(s_rd_en), 32'd0);
        run(1);
        rst_drive = 1'b0;
        taken_log.delete();
        last_log.delete();
        ready_mode = 0;
        drain("t1_drain", 20);
        check_run("t1", 32'h102, 4);

        // Ready toggling every cycle over a 16-word stream.
        preload(32'h200, 16);
        ready_mode = 2;
        drain("t4_drain", 80);
        run(3);
        check_run("t4", 32'h200, 16);

        // Random data, random ready and random empty-flag holes.
        ready_mode = 3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
            hold_empty = ($urandom_range(0, 3) == 0);
            cycle0();
        end
        hold_empty = 1'b0;
        drain("rand_drain", 200);
        taken_log.delete();
        last_log.delete();
        ready_mode = 0;
        run(1);

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        @(negedge clk);
        #1;
        check("stats_words", w0_count, 32'(since_rst_words));
        check("stats_bursts", 32'(b0_count), 32'(since_rst_bursts));
`endif

        // BurstLen=1 instance: every word is the last of its burst.
        q1 = '{32'h31, 32'h32, 32'h33};
        n1 = 0;
        for (int c = 0; c < 20 && n1 < 3; c++) begin
            @(negedge clk);
            f1_empty = (q1.size() == 0);
            f1_data  = (q1.size() != 0) ? q1[0] : 32'h0;
            o1_ready = 1'b1;
            #1;
            if (o1_valid) begin
                check("bl1_last", 32'(o1_last), 32'd1);
                check("bl1_data", o1_data, 32'h31 + 32'(n1));
                n1++;
            end
            p1 = f1_rd_en;
            @(posedge clk);
            if (p1) void'(q1.pop_front());
        end
        check("bl1_count", 32'(n1), 32'd3);
        @(negedge clk);
        f1_empty = 1'b1;
        #1;
        check("bl1_idle", 32'(o1_valid), 32'd0);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
        check("bl1_words", w1_count, 32'd3);
        check("bl1_bursts", 32'(b1_count), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
